multdiv_sequencer: RTL

Multi-cycle signed 32-bit multiply/divide unit that sits beside the single-cycle ALU in the execute stage. It sequences one shared add/subtract step datapath over 32 iterations. Multiply uses shift-add and divide uses restoring division. A fixed-latency completion pulse lets the pipeline stall controller release the stall.

---
 rtl/multdiv_pkg.sv | 20 ++
 rtl/multdiv_addsub.sv | 15 +
 rtl/multdiv_sequencer.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/multdiv_pkg.sv
// Shared definitions for the multi-cycle multiply/divide sequencer.
package multdiv_pkg;

    localparam int ITER_COUNT = 32;
    localparam int LATENCY    = 34;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } seqState;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } opKind;

endpackage

// File: rtl/multdiv_addsub.sv
// Shared add/subtract step for the multiply, divide and sign-fix stages.
module multdiv_addsub #(
    parameter int W = 33
) (
    input  logic [W-1:0] opA,
    input  logic [W-1:0] opB,
    input  logic         subtract,
    output logic [W-1:0] sum,
    output logic         negative
);

    assign sum      = subtract ? (opA - opB) : (opA + opB);
    assign negative = sum[W-1];

endmodule

// File: rtl/multdiv_sequencer.sv
// Signed shift-add multiply / restoring divide over one shared adder, fixed 34-edge latency.
// Build option: define MULTDIV_DIV_EN to include the divider; otherwise ctrl_DIV is ignored.
module multdiv_sequencer
    import multdiv_pkg::*;
#(
    parameter int WIDTH = ITER_COUNT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam int AW = WIDTH + 1;

    seqState          stateReg;
    opKind            opReg;
    logic             pendingReg;
    logic             signReg;
    logic             divZeroReg;
    logic [CW-1:0]    cntReg;
    // hiReg/loReg hold {P_hi, P_lo} for multiply and {R, Q} for divide.
    logic [AW-1:0]    hiReg;
    logic [WIDTH-1:0] loReg;
    logic [AW-1:0]    opndReg;

    logic [WIDTH-1:0] magA;
    logic [WIDTH-1:0] magB;
    logic             canAccept;
    logic             startMul;
    logic             startDiv;
    logic [AW-1:0]    addA;
    logic [AW-1:0]    addB;
    logic [AW-1:0]    addSum;
    logic             addSub;
    logic             addNeg;
    logic [WIDTH-1:0] fixResult;
    logic             fixException;

    assign magA = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;
    assign magB = data_operandB[WIDTH-1] ? (~data_operandB + 1'b1) : data_operandB;

    // A start is sampled into pendingReg first, so iteration begins one edge later.
    assign canAccept = ((stateReg == S_IDLE) || (stateReg == S_DONE)) && !pendingReg;
    assign startMul  = canAccept && ctrl_MULT;
`ifdef MULTDIV_DIV_EN
    assign startDiv  = canAccept && ctrl_DIV && !ctrl_MULT;
`else
    logic unusedDivCtrl;
    assign startDiv      = 1'b0;
    assign unusedDivCtrl = ctrl_DIV ^ addNeg;
`endif

    always_comb begin
        addA   = '0;
        addB   = '0;
        addSub = 1'b0;
        case (stateReg)
            S_MUL: begin
                addA = hiReg;
                addB = loReg[0] ? opndReg : '0;
            end
`ifdef MULTDIV_DIV_EN
            S_DIV: begin
                addA   = {hiReg[WIDTH-1:0], loReg[WIDTH-1]};
                addB   = opndReg;
                addSub = 1'b1;
            end
`endif
            S_FIX: begin
                addB   = {1'b0, loReg};
                addSub = 1'b1;
            end
            default: ;
        endcase
    end

    multdiv_addsub #(.W(AW)) addSubUnit (
        .opA      (addA),
        .opB      (addB),
        .subtract (addSub),
        .sum      (addSum),
        .negative (addNeg)
    );

    // Low bits of the negated product depend only on P_lo; overflow is judged on the magnitude.
    always_comb begin
        fixResult    = signReg ? addSum[WIDTH-1:0] : loReg;
        fixException = 1'b0;
        if (opReg == OP_MUL) begin
            fixException = signReg
                ? ((hiReg != '0) || (loReg[WIDTH-1] && (loReg[WIDTH-2:0] != '0)))
                : ((hiReg != '0) || loReg[WIDTH-1]);
        end else if (divZeroReg) begin
            fixResult    = '0;
            fixException = 1'b1;
        end else begin
            fixException = !signReg && loReg[WIDTH-1];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stateReg       <= S_IDLE;
            opReg          <= OP_MUL;
            pendingReg     <= 1'b0;
            signReg        <= 1'b0;
            divZeroReg     <= 1'b0;
            cntReg         <= '0;
            hiReg          <= '0;
            loReg          <= '0;
            opndReg        <= '0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            case (stateReg)
                S_IDLE, S_DONE: begin
                    stateReg <= S_IDLE;
                    if (pendingReg) begin
                        pendingReg <= 1'b0;
                        busy       <= 1'b1;
`ifdef MULTDIV_DIV_EN
                        stateReg   <= (opReg == OP_DIV) ? S_DIV : S_MUL;
`else
                        stateReg   <= S_MUL;
`endif
                    end else if (startMul || startDiv) begin
                        pendingReg <= 1'b1;
                        opReg      <= startMul ? OP_MUL : OP_DIV;
                        signReg    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                        divZeroReg <= (data_operandB == '0);
                        cntReg     <= '0;
                        hiReg      <= '0;
                        loReg      <= startMul ? magB : magA;
                        opndReg    <= {1'b0, (startMul ? magA : magB)};
                    end
                end
                S_MUL: begin
                    hiReg  <= {1'b0, addSum[AW-1:1]};
                    loReg  <= {addSum[0], loReg[WIDTH-1:1]};
                    cntReg <= cntReg + 1'b1;
                    if (cntReg == CW'(WIDTH - 1)) stateReg <= S_FIX;
                end
`ifdef MULTDIV_DIV_EN
                S_DIV: begin
                    hiReg  <= addNeg ? {hiReg[WIDTH-1:0], loReg[WIDTH-1]} : addSum;
                    loReg  <= {loReg[WIDTH-2:0], !addNeg};
                    cntReg <= cntReg + 1'b1;
                    if (cntReg == CW'(WIDTH - 1)) stateReg <= S_FIX;
                end
`endif
                S_FIX: begin
                    stateReg       <= S_DONE;
                    busy           <= 1'b0;
                    data_resultRDY <= 1'b1;
                    data_result    <= fixResult;
                    data_exception <= fixException;
                end
                default: stateReg <= S_IDLE;
            endcase
        end
    end

endmodule
